// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu_flags_pipe block:
//   - alu_op_e     : 3-bit operation code enumeration
//   - alu_flags_t  : flag bundle that travels with every result beat
//   - FLAGS_CLEAR  : all-zero flag bundle used at reset
//   - op_writes_acc: true for ops that update the internal accumulator
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_CMP    = 3'b010,
        OP_AND    = 3'b011,
        OP_OR     = 3'b100,
        OP_XOR    = 3'b101,
        OP_ACC    = 3'b110,
        OP_CLRACC = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic equal;
        logic greater;
        logic zero;
        logic carry;
        logic overflow;
    } alu_flags_t;

    localparam alu_flags_t FLAGS_CLEAR = '0;

    function automatic logic op_writes_acc(input alu_op_e op);
        return (op == OP_ACC) || (op == OP_CLRACC);
    endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath. Computes the result and the flag bundle
// for one beat from the operands, the op code and the current accumulator.
// For ACC/CLRACC the result is also the new accumulator value; the caller
// decides when to commit it.
//
// Ports:
//   a_i, b_i   : operands (WIDTH bits)
//   acc_i      : current accumulator value (WIDTH bits)
//   op_i       : operation code (alu_op_e)
//   result_o   : operation result (WIDTH bits)
//   flags_o    : equal/greater/zero/carry/overflow for this beat
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] acc_i,
    input  alu_op_e          op_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       flags_o
);

    // One extra bit on each arithmetic path captures carry-out / borrow.
    logic [WIDTH:0] sum_ab;
    logic [WIDTH:0] diff_ab;
    logic [WIDTH:0] sum_acc;
    logic           greater;

    assign sum_ab  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_ab = {1'b0, a_i} - {1'b0, b_i};
    assign sum_acc = {1'b0, acc_i} + {1'b0, a_i};

    // The compare flavour is fixed at elaboration time.
    if (SIGNED_CMP) begin : g_signed_cmp
        assign greater = $signed(a_i) > $signed(b_i);
    end else begin : g_unsigned_cmp
        assign greater = a_i > b_i;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can leave a value unassigned (no latch).
        result_o         = '0;
        flags_o          = FLAGS_CLEAR;

        case (op_i)
            OP_ADD: begin
                result_o         = sum_ab[WIDTH-1:0];
                flags_o.carry    = sum_ab[WIDTH];
                // Signed overflow: operands share a sign the sum does not.
                flags_o.overflow = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                                   (sum_ab[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                result_o         = diff_ab[WIDTH-1:0];
                // Top bit of the widened difference is the borrow (a < b).
                flags_o.carry    = diff_ab[WIDTH];
                // Signed overflow: operand signs differ and the result sign
                // does not follow a.
                flags_o.overflow = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                                   (diff_ab[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_CMP:    result_o = a_i;
            OP_AND:    result_o = a_i & b_i;
            OP_OR:     result_o = a_i | b_i;
            OP_XOR:    result_o = a_i ^ b_i;
            OP_ACC: begin
                // Accumulate reports carry-out only; overflow stays 0.
                result_o      = sum_acc[WIDTH-1:0];
                flags_o.carry = sum_acc[WIDTH];
            end
            OP_CLRACC: result_o = '0;
            default:   result_o = '0;
        endcase

        // Compare flags look at the operands for every op, b included.
        flags_o.equal   = (a_i == b_i);
        flags_o.greater = greater;
        flags_o.zero    = (result_o == '0);
    end

endmodule

// File: rtl/alu_flags_pipe.sv
// -----------------------------------------------------------------------------
// alu_flags_pipe
// Two-stage valid/ready ALU pipeline with flags and an internal accumulator.
//   S1 : captured operands and op code
//   S2 : registered result and flags (drives the outputs)
// A beat accepted in cycle N is presented in cycle N+2 when not stalled; with
// out_ready held high the pipe sustains one beat per cycle. The accumulator
// commits only when an ACC/CLRACC beat moves from S1 into S2.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake
//   a, b, op          : operands and operation code
//   out_valid/out_ready: output handshake
//   result            : operation result
//   equal, greater, zero, carry, overflow : flags of the presented beat
// -----------------------------------------------------------------------------
module alu_flags_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             equal,
    output logic             greater,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    alu_op_e          s1_op_q,    s1_op_d;

    // Stage 2 state (output register) and accumulator
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    alu_flags_t       flags_q,     flags_d;
    logic [WIDTH-1:0] acc_q,       acc_d;

    logic             s2_advance;
    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;

    alu_core #(
        .WIDTH      (WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_core (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .acc_i    (acc_q),
        .op_i     (s1_op_q),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    // S2 can take a new beat when it is empty or its beat leaves this cycle;
    // S1 can take one when it is empty or its beat moves on into S2.
    assign s2_advance = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_advance;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        acc_d       = acc_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d  = a;
                s1_b_d  = b;
                s1_op_d = alu_op_e'(op);
            end
        end

        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = core_result;
                flags_d  = core_flags;
                // Committing here, and only here, makes a stalled ACC beat
                // leave acc untouched and lets back-to-back ACC beats chain.
                if (op_writes_acc(s1_op_q)) begin
                    acc_d = core_result;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, not just the valids,
            // because result and flags must read 0 straight out of reset.
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_ADD;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= FLAGS_CLEAR;
            acc_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign equal     = flags_q.equal;
    assign greater   = flags_q.greater;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;

endmodule

// File: doc/alu_flags_pipe.md
ALU_FLAGS_PIPE -- requirements
Module: alu_flags_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width; legal range 2..32.
REQ-002 Parameter SIGNED_CMP, default 0: 0 = unsigned greater compare, 1 = two's-complement greater compare.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 op  input  3  operation code.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer accepts the result beat.
REQ-013 result  output  WIDTH  operation result.
REQ-014 equal, greater, zero, carry, overflow  output  1 each  flags belonging to the result beat.

Function
REQ-015 Op codes: 000 ADD, 001 SUB, 010 CMP, 011 AND, 100 OR, 101 XOR, 110 ACC, 111 CLRACC.
REQ-016 ADD: result = (a+b) mod 2^WIDTH; carry = carry-out of the sum; overflow = signed overflow.
REQ-017 SUB: result = (a-b) mod 2^WIDTH; carry = 1 when a<b unsigned (borrow); overflow = signed overflow.
REQ-018 CMP: result = a; carry = 0; overflow = 0.
REQ-019 AND, OR, XOR: bitwise result; carry = 0; overflow = 0.
REQ-020 ACC: internal accumulator acc <= acc + a mod 2^WIDTH; result = new acc; carry = carry-out; b is ignored.
REQ-021 CLRACC: acc <= 0; result = 0.
REQ-022 Flags equal = (a==b) and greater = (a>b) are computed on the operands for every op, using the signedness selected by SIGNED_CMP; zero = (result==0).
REQ-023 Pipeline has two register stages: S1 holds the operands and op, S2 holds the result and flags.
REQ-024 Latency: a beat accepted in cycle N appears on out_valid in cycle N+2 when the pipeline is not stalled.
REQ-025 Acceptance: a beat is accepted when in_valid && in_ready; output transfer happens when out_valid && out_ready.
REQ-026 in_ready = !S1.valid || S2 advances this cycle; S2 advances when !out_valid || out_ready.
REQ-027 While out_valid=1 and out_ready=0, result, all flags and out_valid hold stable, and no accepted beat is lost or duplicated.
REQ-028 Throughput: one beat per cycle with out_ready held at 1.
REQ-029 acc updates only when an ACC or CLRACC beat moves from S1 into S2, never while stalled.
REQ-030 Back-to-back ACC beats chain: each beat sees the acc value written by the previous beat.
REQ-031 Wrap-around: accumulator overflow wraps mod 2^WIDTH and sets carry for that beat only.
REQ-032 The last beat is held in S2 until out_ready is asserted, so result and flags stay valid.

Reset
REQ-033 On rst=1 at a clock edge: S1.valid=0, out_valid=0, acc=0, result=0 and all flags=0; in_ready=1 during the first cycle after rst deasserts.
REQ-034 Reset mid-operation discards all in-flight beats; none is emitted after reset.
REQ-035 rst has priority over every handshake occurring in the same cycle.

Structure
REQ-036 Package alu_pkg holds the op-code enumeration/localparams and the flag-bundle typedef.
REQ-037 Combinational sub-module alu_core (WIDTH, SIGNED_CMP) computes result and flags from a, b, op and acc; alu_flags_pipe holds the registers, handshake and acc.

Verification
REQ-038 WIDTH=8, a=10, b=10, op=CMP -> two cycles later equal=1, greater=0, result=10.
REQ-039 a=200, b=100, op=ADD -> result=44, carry=1, overflow=0; a=100, b=100, op=ADD -> result=200, carry=0, overflow=1.
REQ-040 SIGNED_CMP=1, a=8'hF0, b=8'h05, op=CMP -> greater=0; the same stimulus with SIGNED_CMP=0 -> greater=1.
REQ-041 CLRACC, then ACC a=250, then ACC a=10 on consecutive cycles -> results 0, 250, 4; carry=1 on the third beat only.
REQ-042 Stream 5 SUB beats while out_ready is held 0 for 3 cycles -> in_ready drops, outputs stay stable, all 5 results arrive in order with none lost or duplicated.
REQ-043 Assert rst while 2 beats are in flight -> out_valid=0 and acc=0 on the next cycle, and no stale beat appears afterwards.
